// File: rtl/bin_bcd_conv.sv
// 16-bit unsigned binary to 5-digit BCD converter (double dabble), re-running
// only when the measurement value or unit flag changes, with leading-zero mask.
module bin_bcd_conv (
    input  logic        i2c_clk,
    input  logic        rst,
    input  logic [15:0] bin,
    input  logic [1:0]  flag,
    output logic [19:0] bcd,
    output logic [4:0]  blank,
    output logic [1:0]  unit,
    output logic        busy,
    output logic        data_valid
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] snap_bin;
    logic [1:0]  snap_flag;
    logic        force_conv;
    logic [15:0] shreg;
    logic [19:0] work;
    logic [3:0]  bit_cnt;
    logic [19:0] adj;
    logic [4:0]  mask;

    always_ff @(posedge i2c_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (force_conv || ({bin, flag} != {snap_bin, snap_flag})) begin
                    state_next = LOAD;
                end
            end
            LOAD:  state_next = SHIFT;
            SHIFT: begin
                if (bit_cnt == 4'd15) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction on every digit before the shift keeps each digit in 0..9.
    always_comb begin
        adj = work;
        for (int k = 0; k < 5; k++) begin
            if (work[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        mask    = 5'b00000;
        mask[4] = (work[19:16] == 4'd0);
        mask[3] = mask[4] && (work[15:12] == 4'd0);
        mask[2] = mask[3] && (work[11:8] == 4'd0);
        mask[1] = mask[2] && (work[7:4] == 4'd0);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge i2c_clk) begin
        if (rst) begin
            bcd        <= 20'd0;
            blank      <= 5'b11110;
            unit       <= 2'b00;
            data_valid <= 1'b0;
            snap_bin   <= 16'd0;
            snap_flag  <= 2'b00;
            force_conv <= 1'b1;
            shreg      <= 16'd0;
            work       <= 20'd0;
            bit_cnt    <= 4'd0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                LOAD: begin
                    shreg      <= bin;
                    snap_bin   <= bin;
                    snap_flag  <= flag;
                    work       <= 20'd0;
                    bit_cnt    <= 4'd0;
                    force_conv <= 1'b0;
                end
                SHIFT: begin
                    {work, shreg} <= {adj, shreg} << 1;
                    if (bit_cnt != 4'd15) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                DONE: begin
                    bcd        <= work;
                    unit       <= snap_flag;
                    blank      <= mask;
                    data_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_bcd_conv.sv
// Directed self-checking bench for bin_bcd_conv: latency, digit values,
// blanking, mid-conversion input change, idle stability and reset abort.
module tb_bin_bcd_conv;

    logic        i2c_clk = 1'b0;
    logic        rst;
    logic [15:0] bin;
    logic [1:0]  flag;
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic [1:0]  unit;
    logic        busy;
    logic        data_valid;

    int checks = 0;
    int errors = 0;

    bin_bcd_conv dut (
        .i2c_clk    (i2c_clk),
        .rst        (rst),
        .bin        (bin),
        .flag       (flag),
        .bcd        (bcd),
        .blank      (blank),
        .unit       (unit),
        .busy       (busy),
        .data_valid (data_valid)
    );

    always #5 i2c_clk = ~i2c_clk;

    task automatic tick();
        @(posedge i2c_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] b, input logic [1:0] f);
        bin  = b;
        flag = f;
    endtask

    task automatic checkOutput(input string tag, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Steps edges until data_valid is seen, counting edges and busy cycles.
    task automatic runConv(output int edges, output int busy_cycles, output logic seen);
        edges       = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            edges++;
            if (busy) busy_cycles++;
            if (data_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic checkResult(input string tag, input logic [19:0] exp_bcd,
                               input logic [4:0] exp_blank, input logic [1:0] exp_unit);
        checkOutput({tag, "_bcd"},   bcd,            exp_bcd);
        checkOutput({tag, "_blank"}, 20'(blank),     20'(exp_blank));
        checkOutput({tag, "_unit"},  20'(unit),      20'(exp_unit));
    endtask

    initial begin
        int   edges;
        int   bcyc;
        logic seen;
        int   dv_count;
        int   busy_count;

        rst = 1'b1;
        applyStimulus(16'd0, 2'b01);
        repeat (3) tick();
        checkOutput("rst_bcd",   bcd,              20'h00000);
        checkOutput("rst_blank", 20'(blank),       20'h1e);
        checkOutput("rst_unit",  20'(unit),        20'h0);
        checkOutput("rst_busy",  20'(busy),        20'h0);
        checkOutput("rst_dv",    20'(data_valid),  20'h0);

        // Reset release: force_conv starts a conversion of bin = 0
        rst = 1'b0;
        runConv(edges, bcyc, seen);
        checkOutput("s1_seen",  20'(seen),  20'h1);
        checkOutput("s1_edges", 20'(edges), 20'd19);
        checkOutput("s1_busy",  20'(bcyc),  20'd18);
        checkResult("s1", 20'h00000, 5'b11110, 2'b01);
        tick();
        checkOutput("s1_dv_pulse", 20'(data_valid), 20'h0);

        applyStimulus(16'd65535, 2'b11);
        runConv(edges, bcyc, seen);
        checkOutput("s2_seen",  20'(seen),  20'h1);
        checkOutput("s2_edges", 20'(edges), 20'd19);
        checkOutput("s2_busy",  20'(bcyc),  20'd18);
        checkResult("s2", 20'h65535, 5'b00000, 2'b11);

        // 1234 with a change to 999 partway through SHIFT
        applyStimulus(16'd1234, 2'b10);
        repeat (7) tick();
        checkOutput("s3_busy_mid", 20'(busy), 20'h1);
        applyStimulus(16'd999, 2'b10);
        runConv(edges, bcyc, seen);
        checkOutput("s3_seen",  20'(seen),  20'h1);
        checkOutput("s3_edges", 20'(edges), 20'd12);
        checkResult("s3", 20'h01234, 5'b10000, 2'b10);
        runConv(edges, bcyc, seen);
        checkOutput("s4_seen",  20'(seen),  20'h1);
        checkOutput("s4_edges", 20'(edges), 20'd19);
        checkResult("s4", 20'h00999, 5'b11000, 2'b10);

        dv_count   = 0;
        busy_count = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (data_valid) dv_count++;
            if (busy) busy_count++;
        end
        checkOutput("s5_dv_count",   20'(dv_count),   20'd0);
        checkOutput("s5_busy_count", 20'(busy_count), 20'd0);
        checkResult("s5_hold", 20'h00999, 5'b11000, 2'b10);

        // Reset during SHIFT aborts, then force_conv reconverts
        applyStimulus(16'd4321, 2'b01);
        dv_count = 0;
        repeat (9) begin
            tick();
            if (data_valid) dv_count++;
        end
        checkOutput("s6_busy_pre", 20'(busy), 20'h1);
        rst = 1'b1;
        tick();
        checkOutput("s6_rst_busy", 20'(busy),       20'h0);
        checkOutput("s6_rst_dv",   20'(data_valid), 20'h0);
        checkResult("s6_rst", 20'h00000, 5'b11110, 2'b00);
        checkOutput("s6_no_pulse", 20'(dv_count), 20'd0);
        rst = 1'b0;
        runConv(edges, bcyc, seen);
        checkOutput("s6_seen",  20'(seen),  20'h1);
        checkOutput("s6_edges", 20'(edges), 20'd19);
        checkResult("s6", 20'h04321, 5'b10000, 2'b01);

        applyStimulus(16'd7, 2'b00);
        runConv(edges, bcyc, seen);
        checkOutput("s7_seen", 20'(seen), 20'h1);
        checkResult("s7", 20'h00007, 5'b11110, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
